cpu_run_controller: RTL and testbench

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/switch_debouncer.sv | 45 ++++
 rtl/cpu_run_controller.sv | 109 ++++++++++
 tb/tb_cpu_run_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller: run-state encoding and counter widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_ctrl_pkg;

  // Run-state encoding. HALT is zero so that a cleared state register means halted.
  typedef enum logic [1:0] {
    HALT         = 2'd0,
    RUN          = 2'd1,
    STEP         = 2'd2,
    WAIT_RELEASE = 2'd3
  } run_state_t;

  // Width of the per-switch stability counter.
  localparam int unsigned DEB_W = 16;

  // Width of the issued-pulse counter.
  localparam int unsigned COUNT_W = 16;

  // Width of the run-rate divider.
  localparam int unsigned RATE_W = 32;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability filter for one front-panel switch.
// Latency: 2 sync cycles + DEBOUNCE stable cycles before filtered follows raw.
// Backpressure: none; level input, level output.
module switch_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEBOUNCE - 1);

  logic             sync_a;
  logic             sync_b;
  logic [DEB_W-1:0] stable_cnt;

  // Synchronize the raw level, then flip the filtered value only after the
  // synchronized level has disagreed with it for DEBOUNCE cycles in a row.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      filtered   <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b != filtered) begin
        if (stable_cnt == LAST) begin
          filtered   <= sync_b;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer producing a clock-enable pulse train for the CPU datapath.
// Latency: first RUN pulse RATIO cycles after entering RUN; STEP pulse the cycle after the step edge is seen.
// Backpressure: halt_request or a dropped run switch stops pulses immediately, suppressing one due that cycle.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RATIO    = 2,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_switch,
  input  logic               step_switch,
  input  logic               halt_request,
  output logic               cpu_enable,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] enable_count
);

  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATIO - 1);

  run_state_t        state;
  run_state_t        state_nxt;
  logic [RATE_W-1:0] rate_cnt;
  logic [RATE_W-1:0] rate_nxt;
  logic              enable_nxt;
  logic              run_filt;
  logic              step_filt;
  logic              step_prev;

  switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_run_deb (
    .clock    (clock),
    .reset    (reset),
    .raw      (run_switch),
    .filtered (run_filt)
  );

  switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step_deb (
    .clock    (clock),
    .reset    (reset),
    .raw      (step_switch),
    .filtered (step_filt)
  );

  // Next-state, rate divider and pulse decision. Halt conditions are tested
  // before the divider so a pulse due in the same cycle is dropped.
  always_comb begin
    state_nxt  = state;
    rate_nxt   = rate_cnt;
    enable_nxt = 1'b0;
    case (state)
      HALT: begin
        if (run_filt && !halt_request) begin
          state_nxt = RUN;
          rate_nxt  = '0;
        end else if (step_filt && !step_prev && !run_filt) begin
          state_nxt  = STEP;
          enable_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!run_filt || halt_request) begin
          state_nxt = HALT;
        end else if (rate_cnt == RATE_LAST) begin
          rate_nxt   = '0;
          enable_nxt = 1'b1;
        end else begin
          rate_nxt = rate_cnt + 1'b1;
        end
      end
      STEP: begin
        state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!step_filt) begin
          state_nxt = HALT;
        end
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

  // State register plus registered pulse, pulse counter and step-edge history.
  // step_prev tracks in every state so a step held across RUN never looks like an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= HALT;
      rate_cnt     <= '0;
      cpu_enable   <= 1'b0;
      enable_count <= '0;
      step_prev    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rate_cnt   <= rate_nxt;
      cpu_enable <= enable_nxt;
      step_prev  <= step_filt;
      if (enable_nxt) begin
        enable_count <= enable_count + 1'b1;
      end
    end
  end

  assign running = (state == RUN);
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller with a behavioural reference model and pulse scoreboard.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_cpu_run_controller;

  localparam int RATIO = 2;
  localparam int DEB   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_switch;
  logic        step_switch;
  logic        halt_request;
  logic        cpu_enable;
  logic        running;
  logic        halted;
  logic [15:0] enable_count;

  logic        fclk = 1'b0;
  logic        w_reset;
  logic        w_run;
  logic        w_step;
  logic        w_halt;
  logic        w_en;
  logic        w_running;
  logic        w_halted;
  logic [15:0] w_count;

  always #5 clock = ~clock;
  always #1 fclk = ~fclk;

  cpu_run_controller #(.RATIO(RATIO), .DEBOUNCE(DEB)) dut (
    .clock        (clock),
    .reset        (reset),
    .run_switch   (run_switch),
    .step_switch  (step_switch),
    .halt_request (halt_request),
    .cpu_enable   (cpu_enable),
    .running      (running),
    .halted       (halted),
    .enable_count (enable_count)
  );

  cpu_run_controller #(.RATIO(2), .DEBOUNCE(DEB)) wrap_dut (
    .clock        (fclk),
    .reset        (w_reset),
    .run_switch   (w_run),
    .step_switch  (w_step),
    .halt_request (w_halt),
    .cpu_enable   (w_en),
    .running      (w_running),
    .halted       (w_halted),
    .enable_count (w_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the controller described in terms of "cycles since RUN began"
  // and "how long has the synchronized switch disagreed with its filtered value".
  typedef enum int {M_HALT, M_RUN, M_STEP, M_WAIT} mstate_t;
  mstate_t     m_state = M_HALT;
  int          m_phase = 0;
  bit          m_en = 1'b0;
  int unsigned m_count = 0;
  bit          m_step_prev = 1'b0;
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_f  [2];
  int          m_dc [2];
  int unsigned exp_q[$];

  initial begin : model
    bit en_n;
    bit raw [2];
    forever begin
      @(posedge clock);
      raw[0] = run_switch;
      raw[1] = step_switch;
      if (reset) begin
        m_state = M_HALT;
        m_phase = 0;
        m_en = 1'b0;
        m_count = 0;
        m_step_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_f[i] = 1'b0; m_dc[i] = 0;
        end
      end else begin
        en_n = 1'b0;
        case (m_state)
          M_HALT:
            if (m_f[0] && !halt_request) begin
              m_state = M_RUN;
              m_phase = 0;
            end else if (m_f[1] && !m_step_prev && !m_f[0]) begin
              m_state = M_STEP;
              en_n = 1'b1;
            end
          M_RUN:
            if (!m_f[0] || halt_request) begin
              m_state = M_HALT;
            end else begin
              m_phase++;
              en_n = ((m_phase % RATIO) == 0);
            end
          M_STEP: m_state = M_WAIT;
          M_WAIT: if (!m_f[1]) m_state = M_HALT;
          default: m_state = M_HALT;
        endcase
        m_step_prev = m_f[1];
        m_en = en_n;
        if (en_n) begin
          m_count = (m_count + 1) % 65536;
          exp_q.push_back(m_count);
        end
        for (int i = 0; i < 2; i++) begin
          if (m_s2[i] != m_f[i]) begin
            m_dc[i]++;
            if (m_dc[i] == DEB) begin
              m_f[i] = m_s2[i];
              m_dc[i] = 0;
            end
          end else begin
            m_dc[i] = 0;
          end
          m_s2[i] = m_s1[i];
          m_s1[i] = raw[i];
        end
      end
    end
  end

  // Monitor: compares status each cycle and pops the scoreboard on every pulse.
  bit mon_on = 1'b0;
  int pulses_seen = 0;

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_on) begin
        check("running", {31'd0, running}, {31'd0, m_state == M_RUN});
        check("halted", {31'd0, halted}, {31'd0, m_state == M_HALT});
        check("cpu_enable", {31'd0, cpu_enable}, {31'd0, m_en});
        check("count_track", {16'd0, enable_count}, m_count);
        if (cpu_enable) begin
          pulses_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pulse_unexpected: got pulse with count %0h, expected none", enable_count);
          end else begin
            check("pulse_count", {16'd0, enable_count}, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Counter wrap on a second instance clocked faster, running continuously.
  bit wrap_done = 1'b0;
  int w_pulses = 0;

  initial begin : wrap_stim
    w_reset = 1'b1;
    w_run = 1'b1;
    w_step = 1'b0;
    w_halt = 1'b0;
    repeat (3) @(negedge fclk);
    w_reset = 1'b0;
  end

  initial begin : wrap_mon
    forever begin
      @(negedge fclk);
      if (!w_reset && w_en && !wrap_done) begin
        w_pulses++;
        if ((w_pulses % 4096) == 0 || w_pulses >= 65534) begin
          check("wrap_count", {16'd0, w_count}, w_pulses % 65536);
        end
        if (w_pulses == 65536) wrap_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin : main
    int lat;
    int c0;
    int p0;
    int k;
    reset = 1'b1;
    run_switch = 1'b0;
    step_switch = 1'b0;
    halt_request = 1'b0;
    @(negedge clock);
    mon_on = 1'b1;
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_enable", {31'd0, cpu_enable}, 32'd0);
    check("rst_count", {16'd0, enable_count}, 32'd0);
    cyc(2);
    reset = 1'b0;

    // Bounce shorter than the filter never starts RUN.
    run_switch = 1'b1; cyc(1);
    run_switch = 1'b0; cyc(1);
    run_switch = 1'b1; cyc(1);
    run_switch = 1'b0; cyc(20);
    check("bounce_halted", {31'd0, halted}, 32'd1);
    check("bounce_count", {16'd0, enable_count}, 32'd0);

    // Steady run: 2 sync + DEB filter + 1 FSM cycles, then a pulse every RATIO cycles.
    run_switch = 1'b1;
    lat = 0;
    while (!running && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    check("run_latency", lat, 2 + DEB + 1);
    cyc(20);
    check("run_count", {16'd0, enable_count}, 32'd10);

    // Halt request in the cycle a pulse is due: no pulse, halted next cycle.
    k = 0;
    while (!(m_state == M_RUN && ((m_phase + 1) % RATIO) == 0) && k < 10) begin
      @(negedge clock);
      k++;
    end
    c0 = enable_count;
    halt_request = 1'b1;
    @(negedge clock);
    check("hprio_halted", {31'd0, halted}, 32'd1);
    check("hprio_enable", {31'd0, cpu_enable}, 32'd0);
    check("hprio_count", {16'd0, enable_count}, c0);
    halt_request = 1'b0;
    run_switch = 1'b0;
    cyc(12);
    check("run_off_halted", {31'd0, halted}, 32'd1);

    // Single step: one pulse for a long press.
    c0 = enable_count;
    p0 = pulses_seen;
    step_switch = 1'b1; cyc(20);
    step_switch = 1'b0; cyc(15);
    check("step_pulses", pulses_seen - p0, 32'd1);
    check("step_count", {16'd0, enable_count}, (c0 + 1) % 65536);
    check("step_halted", {31'd0, halted}, 32'd1);

    // halt_request does not block stepping.
    p0 = pulses_seen;
    halt_request = 1'b1;
    step_switch = 1'b1; cyc(15);
    step_switch = 1'b0; cyc(15);
    halt_request = 1'b0;
    check("step_under_halt", pulses_seen - p0, 32'd1);

    // Step held across RUN -> HALT must not step.
    run_switch = 1'b1; cyc(12);
    check("held_running", {31'd0, running}, 32'd1);
    step_switch = 1'b1; cyc(12);
    run_switch = 1'b0; cyc(10);
    p0 = pulses_seen;
    cyc(15);
    check("held_no_pulse", pulses_seen - p0, 32'd0);
    check("held_halted", {31'd0, halted}, 32'd1);
    step_switch = 1'b0; cyc(10);

    // Reset in the middle of RUN.
    run_switch = 1'b1; cyc(15);
    check("pre_reset_running", {31'd0, running}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_halted", {31'd0, halted}, 32'd1);
    check("mid_rst_enable", {31'd0, cpu_enable}, 32'd0);
    check("mid_rst_count", {16'd0, enable_count}, 32'd0);
    cyc(2);
    reset = 1'b0;
    run_switch = 1'b0;
    cyc(10);

    // Randomized switch and halt activity against the model.
    for (int s = 0; s < 60; s++) begin
      run_switch = ($urandom_range(0, 2) == 0);
      step_switch = ($urandom_range(0, 1) == 0);
      halt_request = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 14));
    end
    run_switch = 1'b0;
    step_switch = 1'b0;
    halt_request = 1'b0;
    cyc(20);
    check("queue_empty", exp_q.size(), 32'd0);

    for (int i = 0; i < 300000 && !wrap_done; i++) @(posedge fclk);
    if (!wrap_done) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got %0d pulses, expected 65536", w_pulses);
    end else begin
      check("wrap_zero", {16'd0, w_count}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
